dual_port_rom_arbiter: RTL and testbench

//  Shares one registered dual-port ROM (infer_dual_port_rom class, 1-cycle read) among NUM_REQ requesters.

---
 rtl/dual_port_rom_arbiter_pkg.sv | 15 +
 rtl/dual_port_rom_arbiter_rr_pick2.sv | 39 +++
 rtl/dual_port_rom_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dual_port_rom_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_rom_arbiter_pkg.sv
// Shared widths and tag types for the dual-port ROM arbiter and its round-robin picker.
// Pure declarations: no latency, no flow control.
package dprom_arb_pkg;

  localparam int DPROM_ADDR_W = 10;
  localparam int DPROM_DATA_W = 12;

  typedef logic [2:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/dual_port_rom_arbiter_rr_pick2.sv
// Combinational two-winner round-robin picker: first valid from ptr wins A, second wins B.
// Zero latency; never stalls, idle outputs are all-zero.
module rr_pick2
  import dprom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_a,
  output logic [NUM_REQ-1:0] win_b,
  output logic               has_a,
  output logic               has_b
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    win_a = '0;
    win_b = '0;
    has_a = 1'b0;
    has_b = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[w_idx]) begin
        if (!has_a) begin
          win_a[w_idx] = 1'b1;
          has_a        = 1'b1;
        end else if (!has_b) begin
          win_b[w_idx] = 1'b1;
          has_b        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dual_port_rom_arbiter.sv
// Shares one dual-port ROM among NUM_REQ requesters; rsp at grant+ROM_LAT (+1 with DPROM_ARB_RSP_REG_EN).
// Up to two grants per cycle via req_ready; no response backpressure, requesters must sink rsp_valid.
module dual_port_rom_arbiter
  import dprom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DPROM_ADDR_W,
  parameter int DATA_W  = DPROM_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0]         rom_addr_a,
  output logic [ADDR_W-1:0]         rom_addr_b,
  input  logic [DATA_W-1:0]         rom_q_a,
  input  logic [DATA_W-1:0]         rom_q_b
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int LAST  = ROM_LAT - 1;

  logic [PTR_W-1:0]               r_ptr;
  logic [PTR_W-1:0]               w_ptr_nxt;
  logic [NUM_REQ-1:0]             w_req_vld;
  logic [NUM_REQ-1:0]             w_win_a;
  logic [NUM_REQ-1:0]             w_win_b;
  logic                           w_has_a;
  logic                           w_has_b;
  req_id_t                        w_id_a;
  req_id_t                        w_id_b;
  req_id_t                        w_last_id;
  logic [ADDR_W-1:0]              w_addr_a;
  logic [ADDR_W-1:0]              w_addr_b;
  logic [ADDR_W-1:0]              r_addr_a;
  logic [ADDR_W-1:0]              r_addr_b;
  tag_t                           r_tag_a [ROM_LAT];
  tag_t                           r_tag_b [ROM_LAT];
  logic [NUM_REQ-1:0]             w_hit_a;
  logic [NUM_REQ-1:0]             w_hit_b;
  logic [NUM_REQ-1:0][DATA_W-1:0] r_data;

  // Requests are masked during reset so nothing is granted or steered to the ROM.
  assign w_req_vld = rst_n ? req_valid : '0;

  rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .valid (w_req_vld),
    .ptr   (r_ptr),
    .win_a (w_win_a),
    .win_b (w_win_b),
    .has_a (w_has_a),
    .has_b (w_has_b)
  );

  assign req_ready = w_win_a | w_win_b;

  always_comb begin
    w_id_a   = '0;
    w_id_b   = '0;
    w_addr_a = '0;
    w_addr_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_a[i]) begin
        w_id_a   = req_id_t'(i);
        w_addr_a = req_addr[i*ADDR_W +: ADDR_W];
      end
      if (w_win_b[i]) begin
        w_id_b   = req_id_t'(i);
        w_addr_b = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Port B's winner is always later in search order, so it is the last grant when present.
  assign w_last_id = w_has_b ? w_id_b : w_id_a;
  assign w_ptr_nxt = PTR_W'((int'(w_last_id) + 1) % NUM_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
    end else begin
      if (w_has_a) begin
        r_ptr    <= w_ptr_nxt;
        r_addr_a <= w_addr_a;
      end
      if (w_has_b) begin
        r_addr_b <= w_addr_b;
      end
    end
  end

  assign rom_addr_a = w_has_a ? w_addr_a : r_addr_a;
  assign rom_addr_b = w_has_b ? w_addr_b : r_addr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < ROM_LAT; s++) begin
        r_tag_a[s] <= '0;
        r_tag_b[s] <= '0;
      end
    end else begin
      r_tag_a[0] <= '{vld: w_has_a, id: w_id_a};
      r_tag_b[0] <= '{vld: w_has_b, id: w_id_b};
      for (int s = 1; s < ROM_LAT; s++) begin
        r_tag_a[s] <= r_tag_a[s-1];
        r_tag_b[s] <= r_tag_b[s-1];
      end
    end
  end

  // The last tag stage lines up with the ROM output of the same port.
  always_comb begin
    w_hit_a = '0;
    w_hit_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_hit_a[i] = r_tag_a[LAST].vld && (r_tag_a[LAST].id == req_id_t'(i));
      w_hit_b[i] = r_tag_b[LAST].vld && (r_tag_b[LAST].id == req_id_t'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_hit_a[i]) begin
          r_data[i] <= rom_q_a;
        end else if (w_hit_b[i]) begin
          r_data[i] <= rom_q_b;
        end
      end
    end
  end

`ifdef DPROM_ARB_RSP_REG_EN
  logic [NUM_REQ-1:0] r_rsp_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld <= '0;
    end else begin
      r_rsp_vld <= w_hit_a | w_hit_b;
    end
  end

  assign rsp_valid = r_rsp_vld;
  assign rsp_data  = r_data;
`else
  logic [NUM_REQ-1:0][DATA_W-1:0] w_rsp_dat;

  always_comb begin
    w_rsp_dat = r_data;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_hit_a[i]) begin
        w_rsp_dat[i] = rom_q_a;
      end else if (w_hit_b[i]) begin
        w_rsp_dat[i] = rom_q_b;
      end
    end
  end

  assign rsp_valid = w_hit_a | w_hit_b;
  assign rsp_data  = w_rsp_dat;
`endif

endmodule

// File: tb/tb_dual_port_rom_arbiter.sv
// Randomized bench for dual_port_rom_arbiter against a queue-free round-robin/ROM reference model.
module tb_dual_port_rom_arbiter;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 12;
`ifdef DPROM_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [NR*DW-1:0] rsp_data;
  logic [AW-1:0]    rom_addr_a;
  logic [AW-1:0]    rom_addr_b;
  logic [DW-1:0]    rom_q_a;
  logic [DW-1:0]    rom_q_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem [1024];

  dual_port_rom_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ROM_LAT (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rom_addr_a (rom_addr_a),
    .rom_addr_b (rom_addr_b),
    .rom_q_a    (rom_q_a),
    .rom_q_b    (rom_q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered dual-port ROM, one-cycle read.
  always @(posedge clk) begin
    rom_q_a <= mem[rom_addr_a];
    rom_q_b <= mem[rom_addr_b];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int            m_ptr;
  int            na;
  int            nb;
  int            idx;
  logic [AW-1:0] m_last_a;
  logic [AW-1:0] m_last_b;
  logic [DW-1:0] m_data [NR];
  logic [NR-1:0] pv [LAT];
  logic [DW-1:0] pd [LAT][NR];
  logic [NR-1:0] er;
  logic [NR*DW-1:0] exp_flat;

  initial begin
    m_ptr = 0;
    m_last_a = '0;
    m_last_b = '0;
    for (int i = 0; i < NR; i++) m_data[i] = '0;
    for (int s = 0; s < LAT; s++) pv[s] = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_addr_a", 64'(rom_addr_a), 64'd0);
      chk("rst_addr_b", 64'(rom_addr_b), 64'd0);
      m_ptr = 0;
      m_last_a = '0;
      m_last_b = '0;
      for (int i = 0; i < NR; i++) m_data[i] = '0;
      for (int s = 0; s < LAT; s++) pv[s] = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (pv[LAT-1][i]) m_data[i] = pd[LAT-1][i];
        exp_flat[i*DW +: DW] = m_data[i];
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(pv[LAT-1]));
      chk("rsp_data", 64'(rsp_data), 64'(exp_flat));

      na = -1;
      nb = -1;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (req_valid[idx]) begin
          if (na < 0) na = idx;
          else if (nb < 0) nb = idx;
        end
      end
      er = '0;
      if (na >= 0) begin
        er[na] = 1'b1;
        m_last_a = req_addr[na*AW +: AW];
      end
      if (nb >= 0) begin
        er[nb] = 1'b1;
        m_last_b = req_addr[nb*AW +: AW];
      end
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rom_addr_a", 64'(rom_addr_a), 64'(m_last_a));
      chk("rom_addr_b", 64'(rom_addr_b), 64'(m_last_b));

      for (int s = LAT - 1; s > 0; s--) begin
        pv[s] = pv[s-1];
        for (int i = 0; i < NR; i++) pd[s][i] = pd[s-1][i];
      end
      pv[0] = '0;
      if (na >= 0) begin
        pv[0][na] = 1'b1;
        pd[0][na] = mem[m_last_a];
      end
      if (nb >= 0) begin
        pv[0][nb] = 1'b1;
        pd[0][nb] = mem[m_last_b];
      end
      if (nb >= 0) m_ptr = (nb + 1) % NR;
      else if (na >= 0) m_ptr = (na + 1) % NR;
    end
  end

  // Stimulus
  logic [AW-1:0] a [NR];
  logic [NR-1:0] last_rdy;
  logic [NR-1:0] v;
  int            wait2;

  task automatic pack_addr();
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = a[i];
  endtask

  task automatic step(input logic [NR-1:0] vin);
    req_valid = vin;
    #3 last_rdy = req_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < NR; i++) a[i] = '0;
    rst_n = 1'b1;
    req_valid = '0;
    req_addr = '0;
    last_rdy = '0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Requests presented during reset must not be granted.
    for (int i = 0; i < NR; i++) a[i] = AW'($urandom);
    pack_addr();
    step(4'hF);
    step(4'hF);
    rst_n = 1'b1;

    // All four valid from ptr 0.
    a[0] = 10'd5; a[1] = 10'd6; a[2] = 10'd7; a[3] = 10'd8;
    pack_addr();
    step(4'hF);
    chk("s2_c0_ready", 64'(last_rdy), 64'h3);
    step(4'hC);
    chk("s2_c1_ready", 64'(last_rdy), 64'hC);
    repeat (3) step('0);

    // Same address on both ports.
    a[1] = 10'd1023; a[3] = 10'd1023;
    pack_addr();
    step(4'hA);
    chk("s3_ready", 64'(last_rdy), 64'hA);
    repeat (3) step('0);

    // Single requester streaming through the whole address space.
    for (int n = 0; n < 1024; n++) begin
      a[0] = AW'(n);
      pack_addr();
      step(4'h1);
    end
    repeat (3) step('0);

    // Requester 2 held valid while the others toggle randomly.
    wait2 = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NR; i++)
        if (!(req_valid[i] && !last_rdy[i])) a[i] = AW'($urandom_range(0, 1023));
      pack_addr();
      v = NR'($urandom);
      v[2] = 1'b1;
      step(v);
      if (last_rdy[2]) begin
        chk("fairness_wait_le1", 64'(wait2 <= 1), 64'd1);
        wait2 = 0;
      end else begin
        wait2++;
      end
    end
    repeat (3) step('0);

    // Reset right after granting 0 and 1 flushes their reads and rewinds ptr.
    a[0] = 10'd100; a[1] = 10'd200; a[2] = 10'd300; a[3] = 10'd400;
    pack_addr();
    step(4'h3);
    chk("s5_grant", 64'(last_rdy), 64'h3);
    rst_n = 1'b0;
    step('0);
    rst_n = 1'b1;
    step(4'hF);
    chk("s5_resume_ready", 64'(last_rdy), 64'h3);
    step(4'hC);
    chk("s5_second_ready", 64'(last_rdy), 64'hC);
    repeat (4) step('0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
